// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared types and constants for the SDRAM port arbiter.
// Imported by sdram_port_arbiter and sdram_arb_tag_fifo.
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    typedef logic master_id_t;

    localparam master_id_t M_CPU = 1'b0;
    localparam master_id_t M_DMA = 1'b1;

endpackage

// File: rtl/sdram_arb_tag_fifo.sv
// sdram_arb_tag_fifo: owner-id FIFO for reads accepted by the SDRAM
// controller but not yet returned; underflow flags an orphan return.
module sdram_arb_tag_fifo
    import sdram_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_push,
    input  master_id_t             i_push_id,
    input  logic                   i_pop,
    output master_id_t             o_head,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty,
    output logic                   o_underflow
);
    localparam int PW = $clog2(DEPTH);

    master_id_t    r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == (PW+1)'(DEPTH));
    assign w_pop   = i_pop & ~w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO may still push.
    assign w_push  = i_push & (~w_full | w_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (PW+1)'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - (PW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_id;
        end
    end

    assign o_head      = r_mem[r_rd_ptr];
    assign o_count     = r_count;
    assign o_full      = w_full;
    assign o_empty     = w_empty;
    assign o_underflow = i_pop & w_empty;

endmodule

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: shares the SDRAM controller slave between CPU (m0) and DMA (m1).
// Define SDRAM_ARB_CPU_PRIO_EN for fixed CPU priority; round-robin otherwise.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W          = 25,
    parameter int DATA_W          = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,
    output logic [ADDR_W-1:0]   s_address,
    output logic                s_read,
    output logic                s_write,
    output logic [DATA_W-1:0]   s_writedata,
    output logic [DATA_W/8-1:0] s_byteenable,
    input  logic                s_waitrequest,
    input  logic [DATA_W-1:0]   s_readdata,
    input  logic                s_readdatavalid,
    output logic                err_orphan
);
    localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

    state_t        r_state;
    state_t        w_next;
    state_t        w_tie;
    master_id_t    r_last;
    logic          r_err;
    logic          w_m0_req;
    logic          w_m1_req;
    logic          w_gnt_rd;
    logic          w_gnt_wr;
    logic          w_stall;
    logic          w_accept;
    logic          w_push;
    master_id_t    w_owner;
    master_id_t    w_head;
    logic [CW-1:0] w_count;
    logic          w_full;
    logic          w_empty;
    logic          w_underflow;

    assign w_m0_req = m0_read | m0_write;
    assign w_m1_req = m1_read | m1_write;
    assign w_owner  = (r_state == G1) ? M_DMA : M_CPU;

    always_comb begin
        w_gnt_rd = 1'b0;
        w_gnt_wr = 1'b0;
        unique case (r_state)
            G0: begin
                w_gnt_rd = m0_read;
                w_gnt_wr = m0_write;
            end
            G1: begin
                w_gnt_rd = m1_read;
                w_gnt_wr = m1_write;
            end
            default: ;
        endcase
    end

    // Hold off a new read only while every tag slot is in use and no
    // return is freeing one this cycle.
    assign w_stall  = w_gnt_rd & ~s_readdatavalid
                    & (w_count == CW'(MAX_OUTSTANDING));
    assign w_accept = (w_gnt_rd | w_gnt_wr) & ~s_waitrequest & ~w_stall;
    assign w_push   = w_accept & w_gnt_rd;

`ifdef SDRAM_ARB_CPU_PRIO_EN
    assign w_tie = G0;
`else
    assign w_tie = (r_last == M_CPU) ? G1 : G0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_m0_req && w_m1_req) begin
                    w_next = w_tie;
                end else if (w_m0_req) begin
                    w_next = G0;
                end else if (w_m1_req) begin
                    w_next = G1;
                end
            end
            G0: begin
                if (w_accept) begin
`ifdef SDRAM_ARB_CPU_PRIO_EN
                    // Re-arbitrate so a follow-on CPU command beats the DMA.
                    w_next = IDLE;
`else
                    w_next = w_m1_req ? G1 : IDLE;
`endif
                end
            end
            G1: begin
                if (w_accept) begin
                    w_next = w_m0_req ? G0 : IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        s_address      = '0;
        s_writedata    = '0;
        s_byteenable   = '0;
        s_read         = 1'b0;
        s_write        = 1'b0;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        unique case (r_state)
            G0: begin
                s_address      = m0_address;
                s_writedata    = m0_writedata;
                s_byteenable   = m0_byteenable;
                s_read         = m0_read & ~w_stall;
                s_write        = m0_write;
                m0_waitrequest = s_waitrequest | w_stall;
            end
            G1: begin
                s_address      = m1_address;
                s_writedata    = m1_writedata;
                s_byteenable   = m1_byteenable;
                s_read         = m1_read & ~w_stall;
                s_write        = m1_write;
                m1_waitrequest = s_waitrequest | w_stall;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last <= M_DMA;
            r_err  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_last <= w_owner;
            end
            r_err <= r_err | w_underflow;
        end
    end

    sdram_arb_tag_fifo #(
        .DEPTH(MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk        (clk),
        .reset      (reset),
        .i_push     (w_push),
        .i_push_id  (w_owner),
        .i_pop      (s_readdatavalid),
        .o_head     (w_head),
        .o_count    (w_count),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_underflow(w_underflow)
    );

    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;
    assign m0_readdatavalid = s_readdatavalid & ~w_empty & (w_head == M_CPU);
    assign m1_readdatavalid = s_readdatavalid & ~w_empty & (w_head == M_DMA);
    assign err_orphan       = r_err;

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(w_push && w_full && !s_readdatavalid));

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter: vector table, directed corner sequences and a
// randomized transaction-level scoreboard for sdram_port_arbiter.
module tb_sdram_port_arbiter;

    typedef struct packed {
        logic        rst, m0r, m0w, m1r, m1w, sw, sv;
        logic [15:0] rd;
        logic        xr, xw, x0w, x1w, x0v, x1v;
        logic [24:0] xa;
    } vec_t;

    logic        clk, reset;
    logic [24:0] m0_address, m1_address, s_address;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [15:0] m0_writedata, m1_writedata, s_writedata;
    logic [15:0] m0_readdata, m1_readdata, s_readdata;
    logic [1:0]  m0_byteenable, m1_byteenable, s_byteenable;
    logic        m0_waitrequest, m1_waitrequest;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic        s_read, s_write, s_waitrequest, s_readdatavalid;
    logic        err_orphan;

    int n_pass, n_total;

    sdram_port_arbiter dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
        .s_readdatavalid(s_readdatavalid), .err_orphan(err_orphan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, passed=%0d total=%0d",
                 n_pass, n_total);
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        n_total++;
        if (a === e) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, a, e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
        s_waitrequest = 0; s_readdatavalid = 0; s_readdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        step();
        reset = 0;
    endtask

    function automatic vec_t mk(input logic [6:0] i, input logic [15:0] rd,
                                input logic [5:0] x, input logic [24:0] xa);
        return vec_t'({i, rd, x, xa});
    endfunction

    // Transaction-level scoreboard: masters hold a command until accepted,
    // the slave returns accepted reads in order with random data.
    task automatic run_random(input int ncyc);
        bit          pend[2], isrd[2];
        logic [24:0] ad[2];
        logic [15:0] wd[2];
        logic [1:0]  be[2];
        int          wt[2];
        bit          q_own[$];
        logic [15:0] sq[$];
        bit          acc0, acc1, s_acc, e;
        int          m;
        for (int k = 0; k < 2; k++) begin
            pend[k] = 0; isrd[k] = 0; wt[k] = 0;
            ad[k] = '0; wd[k] = '0; be[k] = '0;
        end
        for (int c = 0; c < ncyc; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (!pend[k] && c < ncyc - 200 && $urandom_range(0, 2) == 0) begin
                    pend[k] = 1; isrd[k] = 1'($urandom_range(0, 1));
                    ad[k] = 25'($urandom); wd[k] = 16'($urandom);
                    be[k] = 2'($urandom); wt[k] = 0;
                end
            end
            m0_read = pend[0] & isrd[0]; m0_write = pend[0] & ~isrd[0];
            m1_read = pend[1] & isrd[1]; m1_write = pend[1] & ~isrd[1];
            m0_address = ad[0]; m0_writedata = wd[0]; m0_byteenable = be[0];
            m1_address = ad[1]; m1_writedata = wd[1]; m1_byteenable = be[1];
            s_waitrequest = ($urandom_range(0, 2) == 0);
            s_readdatavalid = (sq.size() > 0) && ($urandom_range(0, 1) == 1);
            s_readdata = s_readdatavalid ? sq[0] : 16'($urandom);
            #1;
            if (s_readdatavalid) begin
                void'(sq.pop_front());
                chk("ret_has_tag", q_own.size() > 0, 1);
                if (q_own.size() > 0) begin
                    e = q_own.pop_front();
                    chk("rnd_rdv0", m0_readdatavalid, e == 0);
                    chk("rnd_rdv1", m1_readdatavalid, e == 1);
                    chk("rnd_rdata", e ? m1_readdata : m0_readdata, s_readdata);
                end
            end else begin
                chk("rnd_no_rdv", m0_readdatavalid | m1_readdatavalid, 0);
            end
            acc0 = pend[0] & ~m0_waitrequest;
            acc1 = pend[1] & ~m1_waitrequest;
            s_acc = (s_read | s_write) & ~s_waitrequest;
            chk("rnd_one_grant", acc0 & acc1, 0);
            chk("rnd_slave_acc", s_acc, acc0 | acc1);
            if (acc0 | acc1) begin
                m = acc1 ? 1 : 0;
                chk("rnd_addr", s_address, ad[m]);
                chk("rnd_sread", s_read, isrd[m]);
                chk("rnd_swrite", s_write, !isrd[m]);
                if (!isrd[m]) begin
                    chk("rnd_wdata", s_writedata, wd[m]);
                    chk("rnd_be", s_byteenable, be[m]);
                end
                chk("rnd_wait_bound", wt[m] <= 100, 1);
                if (isrd[m]) q_own.push_back(m[0]);
                pend[m] = 0;
            end
            if (s_read & ~s_waitrequest) sq.push_back(16'($urandom));
            chk("rnd_outstanding", q_own.size() <= 4, 1);
            for (int k = 0; k < 2; k++) if (pend[k]) wt[k]++;
            step();
        end
        chk("rnd_drain", pend[0] | pend[1] | (q_own.size() != 0), 0);
        chk("rnd_err", err_orphan, 0);
    endtask

    initial begin
        vec_t v;
        vec_t vq[$];
        int   n;
        n_pass = 0; n_total = 0;
        reset = 1;
        idle_inputs();
        m0_address = 25'h10; m1_address = 25'h20;
        m0_writedata = 16'h1111; m1_writedata = 16'h2222;
        m0_byteenable = 2'b11; m1_byteenable = 2'b01;
        repeat (2) step();
        reset = 0;
        #1;
        chk("rst_m0_wait", m0_waitrequest, 1);
        chk("rst_m1_wait", m1_waitrequest, 1);
        chk("rst_sread", s_read, 0);
        chk("rst_swrite", s_write, 0);
        chk("rst_rdv", m0_readdatavalid | m1_readdatavalid, 0);
        chk("rst_err", err_orphan, 0);

        // single m0 read: 2 wait cycles, data 3 cycles after acceptance
        vq.push_back(mk(7'b1000000, 16'h0000, 6'b000000, 25'h00));
        vq.push_back(mk(7'b0100010, 16'h0000, 6'b001100, 25'h00));
        vq.push_back(mk(7'b0100010, 16'h0000, 6'b101100, 25'h10));
        vq.push_back(mk(7'b0100010, 16'h0000, 6'b101100, 25'h10));
        vq.push_back(mk(7'b0100000, 16'h0000, 6'b100100, 25'h10));
        vq.push_back(mk(7'b0000000, 16'h0000, 6'b001100, 25'h00));
        vq.push_back(mk(7'b0000000, 16'h0000, 6'b001100, 25'h00));
        vq.push_back(mk(7'b0000001, 16'hBEEF, 6'b001110, 25'h00));
        vq.push_back(mk(7'b0000000, 16'h0000, 6'b001100, 25'h00));
        // both write from reset, round-robin
        vq.push_back(mk(7'b1000000, 16'h0000, 6'b000000, 25'h00));
        vq.push_back(mk(7'b0010100, 16'h0000, 6'b001100, 25'h00));
        vq.push_back(mk(7'b0010110, 16'h0000, 6'b011100, 25'h10));
        vq.push_back(mk(7'b0010100, 16'h0000, 6'b010100, 25'h10));
        vq.push_back(mk(7'b0000100, 16'h0000, 6'b011000, 25'h20));
        vq.push_back(mk(7'b0010100, 16'h0000, 6'b001100, 25'h00));
        vq.push_back(mk(7'b0010100, 16'h0000, 6'b010100, 25'h10));
        vq.push_back(mk(7'b0000100, 16'h0000, 6'b011000, 25'h20));
        vq.push_back(mk(7'b0000000, 16'h0000, 6'b001100, 25'h00));

        foreach (vq[i]) begin
            v = vq[i];
            if (v.rst) begin
                do_reset();
                continue;
            end
            m0_read = v.m0r; m0_write = v.m0w;
            m1_read = v.m1r; m1_write = v.m1w;
            s_waitrequest = v.sw; s_readdatavalid = v.sv; s_readdata = v.rd;
            #1;
            chk($sformatf("v%0d s_read", i), s_read, v.xr);
            chk($sformatf("v%0d s_write", i), s_write, v.xw);
            chk($sformatf("v%0d m0_wait", i), m0_waitrequest, v.x0w);
            chk($sformatf("v%0d m1_wait", i), m1_waitrequest, v.x1w);
            chk($sformatf("v%0d m0_rdv", i), m0_readdatavalid, v.x0v);
            chk($sformatf("v%0d m1_rdv", i), m1_readdatavalid, v.x1v);
            chk($sformatf("v%0d m0_rdata", i), m0_readdata, v.rd);
            chk($sformatf("v%0d m1_rdata", i), m1_readdata, v.rd);
            if (v.xr | v.xw) chk($sformatf("v%0d s_addr", i), s_address, v.xa);
            step();
        end

        // outstanding-read limit and same-cycle unblock
        do_reset();
        m1_read = 1;
        n = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (!m1_waitrequest) n++;
            step();
        end
        #1;
        chk("lim_accepted", n, 4);
        chk("lim_sread", s_read, 0);
        chk("lim_m1_wait", m1_waitrequest, 1);
        step();
        s_readdatavalid = 1; s_readdata = 16'h5A5A;
        #1;
        chk("unblk_sread", s_read, 1);
        chk("unblk_m1_wait", m1_waitrequest, 0);
        chk("unblk_m1_rdv", m1_readdatavalid, 1);
        chk("unblk_m0_rdv", m0_readdatavalid, 0);
        chk("unblk_rdata", m1_readdata, 16'h5A5A);
        step();
        s_readdatavalid = 0; m1_read = 0;

        // orphan return on an empty FIFO
        do_reset();
        s_readdatavalid = 1; s_readdata = 16'hDEAD;
        #1;
        chk("orph_rdv", m0_readdatavalid | m1_readdatavalid, 0);
        chk("orph_err_now", err_orphan, 0);
        step();
        s_readdatavalid = 0;
        #1;
        chk("orph_err_set", err_orphan, 1);
        repeat (3) step();
        #1;
        chk("orph_err_sticky", err_orphan, 1);
        do_reset();
        #1;
        chk("orph_err_clr", err_orphan, 0);

        // reset while granted to m1 with two reads outstanding
        do_reset();
        m1_read = 1;
        for (int c = 0; c < 5; c++) begin
            s_waitrequest = (c >= 4);
            step();
        end
        #1;
        chk("mid_g1_held", s_read, 1);
        reset = 1; m1_read = 0; s_waitrequest = 0;
        step();
        reset = 0;
        s_readdatavalid = 1; s_readdata = 16'h7777;
        #1;
        chk("mid_m0_wait", m0_waitrequest, 1);
        chk("mid_m1_wait", m1_waitrequest, 1);
        chk("mid_sread", s_read, 0);
        chk("mid_rdv", m0_readdatavalid | m1_readdatavalid, 0);
        chk("mid_err_now", err_orphan, 0);
        step();
        s_readdatavalid = 0;
        #1;
        chk("mid_err_late", err_orphan, 1);

        do_reset();
        run_random(3000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sdram_port_arbiter.md
# sdram_port_arbiter

- Shares the single Avalon-MM slave port of the SDRAM controller between two masters:
  - m0: the Plasma CPU data bus.
  - m1: the SD-card/SPI DMA engine.
- Arbitrates between them, holds each command stable while the controller stalls, and returns pipelined read data to the master that issued it.
- Sits between the Plasma SoC interconnect and the SDRAM controller inside the DE1-SoC system.

## Interface
Parameters:
- ADDR_W, 25, word address width in 16-bit words (64 MiB SDRAM).
- DATA_W, 16, data width; byteenable is DATA_W/8 bits.
- MAX_OUTSTANDING, 4, maximum accepted reads not yet returned; power of two, at least 2.

Ports:
- Clocking: one clock; reset is synchronous and active-high.
  - clk  in  1  system clock.
  - reset  in  1  synchronous, active-high.
- mX_* (X = 0, 1), one set per master:
  - mX_address  in  ADDR_W  word address.
  - mX_read, mX_write  in  1  command strobes; never both high.
  - mX_writedata  in  DATA_W  write data.
  - mX_byteenable  in  DATA_W/8  byte enables.
  - mX_waitrequest  out  1  command not accepted.
  - mX_readdata  out  DATA_W  read data.
  - mX_readdatavalid  out  1  read data valid.
- s_* (to the controller): s_address, s_read, s_write, s_writedata, s_byteenable out; s_waitrequest, s_readdata, s_readdatavalid in. Widths match the master side.
- err_orphan  out  1  sticky; set when read data arrives with no outstanding read.

## Operation
- Grant FSM, states IDLE, G0, G1:
  - IDLE: no command is driven to the slave.
    - If exactly one master requests (read or write), go to that master's G state.
    - If both request, go to the state selected by the priority rule (see Configuration).
  - Gx: master x's address, data, byteenable and strobes pass combinationally to s_*.
    - mX_waitrequest = s_waitrequest OR read-stall.
    - On acceptance (strobe high and waitrequest low): if the other master is requesting, go to G(other); otherwise go to IDLE.
    - While not accepted, stay in Gx. The grant is never withdrawn mid-command.
- A master without the grant always sees waitrequest=1.
- Round-robin pointer `last` is updated to x on every acceptance in Gx.
- Read-stall: asserted when a read is pending, the tag FIFO count equals MAX_OUTSTANDING, and s_readdatavalid is low. While stalled, s_read is forced to 0.
- Tag FIFO (depth MAX_OUTSTANDING, 1-bit entries):
  - Push: the owner id on every accepted read.
  - Pop: on each s_readdatavalid.
  - Push and pop in the same cycle keep the count unchanged; this is legal when the FIFO is full.
  - Writes are never tagged.
- Read return:
  - s_readdata is broadcast to both mX_readdata.
  - mX_readdatavalid = s_readdatavalid AND (FIFO head == X).
- Empty FIFO with s_readdatavalid high: data is dropped, err_orphan is set, and the count stays at 0.
- Reset, including mid-operation: state IDLE, last=1 (m0 wins first tie), FIFO cleared, err_orphan=0. The controller is reset together with this block.

## Timing
- Reset values:
  - mX_waitrequest=1, mX_readdatavalid=0.
  - s_read=0, s_write=0; other s_* outputs are don't-care.
  - err_orphan=0.
- Request latency:
  - Request first seen in IDLE at cycle N: command is on s_* at N+1.
  - Earliest acceptance is N+1, so minimum waitrequest is 1 cycle.
- Back-to-back commands:
  - Same master, no contention: one IDLE bubble, so one command every 2 cycles.
  - Alternating masters under contention: no bubble.
- Read return: zero added latency; mX_readdatavalid follows s_readdatavalid combinationally in the same cycle.
- Ordering: return order is guaranteed by in-order completion in the controller.

## Configuration
- Macro SDRAM_ARB_CPU_PRIO_EN:
  - Defined: fixed priority. m0 wins every tie, including in Gx on acceptance. m1 is starved while m0 streams.
  - Undefined: round-robin. On a tie, the master other than `last` wins.

## Structure
- Package sdram_arb_pkg holds:
  - state enum (IDLE, G0, G1).
  - master_id_t (1 bit).
  - constants M_CPU=0, M_DMA=1.
- Sub-module sdram_arb_tag_fifo:
  - Circular buffer with count and full/empty outputs.
  - Simultaneous push and pop supported.
  - Pop on empty is ignored and reported as underflow; the top level turns underflow into err_orphan.

## Test plan
- Single m0 read at 0x10, slave waitrequest 2 cycles, data 0xBEEF after 3 cycles:
  - s_read asserted 3 cycles.
  - m0_readdatavalid for 1 cycle with 0xBEEF; m1_readdatavalid stays 0.
- m0 and m1 both write from reset (round-robin):
  - m0 accepted first, then m1 with no bubble.
  - Repeat with both requesting again: m0 granted next, since last=m1 favours m0.
- m1 issues 5 reads, slave returns nothing (MAX_OUTSTANDING=4):
  - 4 reads accepted; the 5th has s_read=0 and m1_waitrequest=1.
  - One return unblocks it in the same cycle.
- Interleaved reads m0, m1, m0 with staggered returns: readdatavalid routes to m0, m1, m0 in order, each with the correct data.
- s_readdatavalid with an empty FIFO: err_orphan rises the next cycle and stays high until reset.
- Reset asserted while in G1 with 2 outstanding reads:
  - Next cycle: state IDLE, all waitrequest=1, FIFO empty.
  - Late returned data sets err_orphan.
